rram_readout_ctrl: RTL and testbench

//  Sequences one power-down / enable / settle / capture cycle of a ring-RAM cell array.

---
 rtl/rram_ctrl_pkg.sv | 28 ++
 rtl/rram_sync.sv | 25 ++
 rtl/rram_readout_ctrl.sv | 148 ++++++++++++++
 tb/tb_rram_readout_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rram_ctrl_pkg.sv
// Shared types and constants for the ring-RAM readout controller.
// Holds the FSM state encoding, the synchroniser depth and a constant-safe clog2.
package rram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OFF,
    SETTLE,
    SYNC,
    CAPTURE,
    STREAM
  } state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rram_sync.sv
// Multi-flop synchroniser that brings the asynchronous cell outputs into the clk domain.
// Flops are held together by attributes so placement keeps the chain tight and intact.
module rram_sync
  import rram_ctrl_pkg::*;
#(
  parameter int g_WIDTH = 64
) (
  input  logic               clk,
  input  logic [g_WIDTH-1:0] d,
  output logic [g_WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *) logic [g_WIDTH-1:0] stage [SYNC_STAGES];

  // NOTE: synchroniser flops carry no reset; a reset path would only add skew to the chain.
  always_ff @(posedge clk) begin
    stage[0] <= d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/rram_readout_ctrl.sv
// Sequences power-down / enable / settle / capture of the ring-RAM array and
// streams the captured snapshot out as valid/ready words.
module rram_readout_ctrl
  import rram_ctrl_pkg::*;
#(
  parameter int g_RRAM_CELLS = 64,
  parameter int g_OUT_W      = 32,
  parameter int g_CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [g_CNT_W-1:0]      off_cycles,
  input  logic [g_CNT_W-1:0]      settle_cycles,
  output logic [g_RRAM_CELLS-1:0] en,
  input  logic [g_RRAM_CELLS-1:0] cell_q,
  output logic [g_OUT_W-1:0]      dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    done
);

  localparam int NW    = g_RRAM_CELLS / g_OUT_W;
  localparam int IDX_W = (clog2(NW) < 1) ? 1 : clog2(NW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  state_t                  state;
  logic                    en_bit;
  logic [g_CNT_W-1:0]      off_cnt;
  logic [g_CNT_W-1:0]      settle_cnt;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [g_RRAM_CELLS-1:0] cell_sync;
  logic [g_RRAM_CELLS-1:0] shadow;

  rram_sync #(.g_WIDTH(g_RRAM_CELLS)) u_sync (
    .clk (clk),
    .d   (cell_q),
    .q   (cell_sync)
  );

  // A programmed count of zero behaves as one; the counters hold count-1.
  function automatic logic [g_CNT_W-1:0] count_load(input logic [g_CNT_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

  function automatic logic [g_OUT_W-1:0] word_of(input logic [g_RRAM_CELLS-1:0] v,
                                                 input logic [IDX_W-1:0]        i);
    logic [g_RRAM_CELLS-1:0] shifted;
    shifted = v >> (int'(i) * g_OUT_W);
    return shifted[g_OUT_W-1:0];
  endfunction

  assign idx_next = idx + 1'b1;
  assign en       = {g_RRAM_CELLS{en_bit}};
  assign busy     = (state != IDLE);

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      en_bit     <= 1'b0;
      off_cnt    <= '0;
      settle_cnt <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        en_bit     <= 1'b0;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              off_cnt    <= count_load(off_cycles);
              settle_cnt <= count_load(settle_cycles);
              state      <= OFF;
            end
          end
          OFF: begin
            if (off_cnt == '0) begin
              en_bit <= 1'b1;
              state  <= SETTLE;
            end else begin
              off_cnt <= off_cnt - 1'b1;
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              off_cnt <= g_CNT_W'(SYNC_STAGES - 1);
              state   <= SYNC;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          SYNC: begin
            // The off counter is idle here, so it times the synchroniser fill.
            if (off_cnt == '0) begin
              state <= CAPTURE;
            end else begin
              off_cnt <= off_cnt - 1'b1;
            end
          end
          CAPTURE: begin
            en_bit     <= 1'b0;
            idx        <= '0;
            dout       <= word_of(cell_sync, '0);
            dout_valid <= 1'b1;
            dout_last  <= (LAST_IDX == '0);
            state      <= STREAM;
          end
          STREAM: begin
            if (dout_ready) begin
              if (dout_last) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
                done       <= 1'b1;
                state      <= IDLE;
              end else begin
                idx       <= idx_next;
                dout      <= word_of(shadow, idx_next);
                dout_last <= (idx_next == LAST_IDX);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: the snapshot is a pure data register, so it is left unreset; only CAPTURE writes it.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      shadow <= cell_sync;
    end
  end

endmodule

// File: tb/tb_rram_readout_ctrl.sv
// Randomised self-checking bench for rram_readout_ctrl; expectations come from
// cycle arithmetic on the off/settle counts and from the captured 64-bit value.
module tb_rram_readout_ctrl;

  localparam int CELLS = 64;
  localparam int OW    = 32;
  localparam int CW    = 16;
  localparam int NW    = CELLS / OW;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CW-1:0]    off_cycles;
  logic [CW-1:0]    settle_cycles;
  logic [CELLS-1:0] en;
  logic [CELLS-1:0] cell_q;
  logic [OW-1:0]    dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_bad    = 0;

  rram_readout_ctrl #(
    .g_RRAM_CELLS (CELLS),
    .g_OUT_W      (OW),
    .g_CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .off_cycles    (off_cycles),
    .settle_cycles (settle_cycles),
    .en            (en),
    .cell_q        (cell_q),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_last     (dout_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"}, en, '0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_last"}, dout_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Full read: start at cycle 0, check en/busy/valid timing, then stream with
  // backpressure and compare words, last flag and the done pulse.
  task automatic run_read(input int o, input int s, input logic [63:0] val,
                          input int hold, input int pct, input bit extra_start,
                          input bit change_after);
    int oe, se, t_cap, widx, n;
    logic [OW-1:0] exp_w [NW];
    oe = (o == 0) ? 1 : o;
    se = (s == 0) ? 1 : s;
    t_cap = oe + se + 3;
    for (int i = 0; i < NW; i++) exp_w[i] = val[i*OW +: OW];
    cell_q        = val;
    off_cycles    = CW'(o);
    settle_cycles = CW'(s);
    dout_ready    = 1'b0;
    start         = 1'b1;
    for (int k = 1; k <= t_cap + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (extra_start && k == 2) begin
        start         = 1'b1;
        off_cycles    = CW'(o + 7);
        settle_cycles = CW'(s + 9);
      end
      check("en_timing", en, (k >= oe + 1 && k <= t_cap) ? '1 : '0);
      check("busy_run", busy, 1);
      check("valid_rise", dout_valid, (k == t_cap + 1));
      if (change_after && k == t_cap + 1) cell_q = ~val;
    end
    start = 1'b0;
    widx = 0;
    n = 0;
    while (widx < NW && n < 300) begin
      check("valid_hold", dout_valid, 1);
      check("dout_word", dout, exp_w[widx]);
      check("last_flag", dout_last, (widx == NW - 1));
      check("done_early", done, 0);
      dout_ready = (n >= hold) && ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (dout_ready) widx++;
      n++;
    end
    dout_ready = 1'b0;
    if (widx < NW) check("stream_timeout", 0, 1);
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("valid_end", dout_valid, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic start_and_wait_valid(input int o, input int s, input logic [63:0] val);
    int n;
    cell_q        = val;
    off_cycles    = CW'(o);
    settle_cycles = CW'(s);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!dout_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!dout_valid) check("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [63:0] v;
    rst = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
    off_cycles = '0; settle_cycles = '0; cell_q = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_dout", dout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic read and backpressure on the first word.
    v = 64'hDEAD_BEEF_0123_4567;
    run_read(3, 5, v, 0, 100, 1'b0, 1'b0);
    run_read(3, 5, v, 10, 100, 1'b0, 1'b0);

    // Zero counts behave as one.
    run_read(0, 0, {$urandom, $urandom}, 0, 100, 1'b0, 1'b0);

    // Abort during SETTLE with a simultaneous start.
    off_cycles = 2; settle_cycles = 6; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_idle_outputs("abort_settle");
    repeat (12) @(negedge clk);
    check("abort_no_valid", dout_valid, 0);
    check("abort_still_idle", busy, 0);
    run_read(2, 6, {$urandom, $urandom}, 0, 100, 1'b0, 1'b0);

    // Abort coincident with the final transfer: the word goes, done does not.
    start_and_wait_valid(1, 2, 64'h1111_2222_3333_4444);
    dout_ready = 1'b1;
    @(negedge clk);
    check("abort_final_word", dout, 32'h1111_2222);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; dout_ready = 1'b0;
    check_idle_outputs("abort_final");
    @(negedge clk);
    check("abort_final_no_done", done, 0);

    // Reset in STREAM after word 0 has transferred.
    start_and_wait_valid(2, 3, 64'hA5A5_5A5A_F00D_CAFE);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    check("rst_pre_word1", dout, 32'hA5A5_5A5A);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_stream");
    check("rst_stream_dout", dout, 0);
    rst = 1'b0;
    @(negedge clk);
    run_read(2, 3, {$urandom, $urandom}, 0, 100, 1'b0, 1'b0);

    // cell_q changes after capture and a start arrives while busy.
    run_read(4, 2, 64'h0F0F_1234_8765_F0F0, 3, 100, 1'b1, 1'b1);

    // Randomised reads with random backpressure.
    for (int it = 0; it < 8; it++) begin
      run_read($urandom_range(0, 6), $urandom_range(0, 6), {$urandom, $urandom},
               $urandom_range(0, 3), $urandom_range(40, 100), it[0], it[1]);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
